compressed_word_packer: RTL and testbench

- Sequential, parametrised successor to the fixed 68/34-bit OR-merge stage of the compressor datapath.
- Accepts a stream of variable-length compressed codewords, each 0..MAX_IN_WIDTH bits, right-aligned.
- Packs them LSB-first and gap-free into an ACC_WIDTH accumulator, and emits fixed OUT_WIDTH beats over a valid/ready handshake.
- On an input marked last, drains any partial remainder zero-padded and tagged o_last; sits between the pattern encoder and the compressed-line write buffer.

---
 rtl/compressed_word_packer_if.sv | 34 +++
 rtl/compressed_word_packer.sv | 142 ++++++++++++++
 tb/tb_compressed_word_packer.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/compressed_word_packer_if.sv
// rtl/compressed_word_packer_if.sv - codeword-in / beat-out bus of the word packer
// Ports (named from the packer's side):
//   i_valid/o_ready/i_data/i_len/i_last : codeword stream into the packer
//   o_valid/i_ready/o_data/o_bits/o_last : packed beat stream out of the packer
//   o_fill                               : accumulator occupancy status
// Modports: master = upstream/downstream environment, slave = packer.
interface compressed_word_packer_if #(
  parameter int MAX_IN_WIDTH = 68,
  parameter int LEN_WIDTH    = 7,
  parameter int OUT_WIDTH    = 68,
  parameter int CNT_WIDTH    = 8
);
  logic                    i_valid;
  logic                    o_ready;
  logic [MAX_IN_WIDTH-1:0] i_data;
  logic [LEN_WIDTH-1:0]    i_len;
  logic                    i_last;
  logic                    o_valid;
  logic                    i_ready;
  logic [OUT_WIDTH-1:0]    o_data;
  logic [LEN_WIDTH-1:0]    o_bits;
  logic                    o_last;
  logic [CNT_WIDTH-1:0]    o_fill;

  modport master (
    output i_valid, i_data, i_len, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_bits, o_last, o_fill
  );

  modport slave (
    input  i_valid, i_data, i_len, i_last, i_ready,
    output o_ready, o_valid, o_data, o_bits, o_last, o_fill
  );
endinterface

// File: rtl/compressed_word_packer.sv
// rtl/compressed_word_packer.sv - packs variable-length codewords LSB-first into fixed-width beats
// Ports:
//   i_clk     : clock, all state on rising edge
//   i_reset_n : asynchronous active-low reset
//   bus       : compressed_word_packer_if.slave (codeword in, beat out, fill status)
module compressed_word_packer #(
  parameter int MAX_IN_WIDTH = 68,
  parameter int LEN_WIDTH    = 7,
  parameter int OUT_WIDTH    = 68,
  parameter int ACC_WIDTH    = 136,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  compressed_word_packer_if.slave   bus
);

  if (ACC_WIDTH < OUT_WIDTH + MAX_IN_WIDTH) begin : g_chk_acc
    $error("ACC_WIDTH must be >= OUT_WIDTH + MAX_IN_WIDTH");
  end
  if ((1 << CNT_WIDTH) <= ACC_WIDTH) begin : g_chk_cnt
    $error("CNT_WIDTH must hold ACC_WIDTH");
  end
  if ((1 << LEN_WIDTH) <= MAX_IN_WIDTH || (1 << LEN_WIDTH) <= OUT_WIDTH) begin : g_chk_len
    $error("LEN_WIDTH must hold MAX_IN_WIDTH and OUT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] C_OUT       = CNT_WIDTH'(OUT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] C_READY_MAX = CNT_WIDTH'(ACC_WIDTH - MAX_IN_WIDTH);
  localparam logic [LEN_WIDTH-1:0] C_MAX_LEN   = LEN_WIDTH'(MAX_IN_WIDTH);

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  state_t                r_state;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [CNT_WIDTH-1:0]  r_fill;

  state_t                w_state_nxt;
  logic [ACC_WIDTH-1:0]  w_acc_nxt;
  logic [CNT_WIDTH-1:0]  w_fill_nxt;

  logic                  w_ready;
  logic                  w_valid;
  logic                  w_last;
  logic [LEN_WIDTH-1:0]  w_bits;
  logic [CNT_WIDTH-1:0]  w_out_take;

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic [LEN_WIDTH-1:0]  w_len;
  logic [MAX_IN_WIDTH-1:0] w_mask;
  logic [MAX_IN_WIDTH-1:0] w_data_m;
  logic [ACC_WIDTH-1:0]  w_acc_sh;
  logic [CNT_WIDTH-1:0]  w_fill_sh;

  // Output decode depends only on registered state and fill, so there is
  // no combinational path from i_valid/i_ready to o_ready/o_valid.
  always_comb begin
    w_out_take = (r_fill < C_OUT) ? r_fill : C_OUT;
    w_ready    = 1'b0;
    w_valid    = 1'b0;
    w_last     = 1'b0;
    w_bits     = '0;
    case (r_state)
      S_FILL: begin
        w_ready = (r_fill <= C_READY_MAX);
        w_valid = (r_fill >= C_OUT);
        w_bits  = w_valid ? LEN_WIDTH'(OUT_WIDTH) : '0;
      end
      S_DRAIN: begin
        w_valid = 1'b1;
        w_last  = (r_fill <= C_OUT);
        w_bits  = LEN_WIDTH'(w_out_take);
      end
      default: begin
      end
    endcase
  end

  // Shift-out happens before insert, so a codeword accepted in the same
  // cycle as a beat lands right after the bits that remain.
  always_comb begin
    w_in_fire  = bus.i_valid & w_ready;
    w_out_fire = w_valid & bus.i_ready;
    w_len      = (bus.i_len > C_MAX_LEN) ? C_MAX_LEN : bus.i_len;
    w_mask     = '0;
    for (int i = 0; i < MAX_IN_WIDTH; i++) begin
      w_mask[i] = (i < int'(w_len));
    end
    w_data_m   = bus.i_data & w_mask;
    w_acc_sh   = w_out_fire ? (r_acc >> OUT_WIDTH) : r_acc;
    w_fill_sh  = w_out_fire ? (r_fill - w_out_take) : r_fill;

    w_acc_nxt   = w_acc_sh;
    w_fill_nxt  = w_fill_sh;
    w_state_nxt = r_state;

    if (w_in_fire) begin
      w_acc_nxt  = w_acc_sh | (ACC_WIDTH'(w_data_m) << w_fill_sh);
      w_fill_nxt = w_fill_sh + CNT_WIDTH'(w_len);
    end

    case (r_state)
      S_FILL: begin
        // Closing a block always drains, even an empty one.
        if (w_in_fire && bus.i_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_out_fire && w_last) begin
          w_state_nxt = S_FILL;
          w_acc_nxt   = '0;
          w_fill_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_FILL;
      r_acc   <= '0;
      r_fill  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_fill  <= w_fill_nxt;
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_valid = w_valid;
  assign bus.o_last  = w_last;
  assign bus.o_bits  = w_bits;
  assign bus.o_data  = w_valid ? r_acc[OUT_WIDTH-1:0] : '0;
  assign bus.o_fill  = r_fill;

endmodule

// File: tb/tb_compressed_word_packer.sv
// tb/tb_compressed_word_packer.sv - scoreboard bench for compressed_word_packer
module tb_compressed_word_packer;
  localparam int MAXW = 68;
  localparam int LENW = 7;
  localparam int OUTW = 68;
  localparam int ACCW = 136;
  localparam int CNTW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  compressed_word_packer_if #(
    .MAX_IN_WIDTH(MAXW), .LEN_WIDTH(LENW), .OUT_WIDTH(OUTW), .CNT_WIDTH(CNTW)
  ) bus ();

  compressed_word_packer #(
    .MAX_IN_WIDTH(MAXW), .LEN_WIDTH(LENW), .OUT_WIDTH(OUTW),
    .ACC_WIDTH(ACCW), .CNT_WIDTH(CNTW)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the accepted bitstream in order, plus the length of
  // each closed block. Beats must carve this stream into 68-bit pieces.
  bit exp_bits[$];
  int blk_q[$];
  int cur_blk = 0;
  int emitted = 0;
  int n_beats = 0;
  int n_last  = 0;
  logic [OUTW-1:0] last_data = '0;
  int last_bits = 0;
  int rdy_mode = 1;

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [OUTW-1:0] got, input logic [OUTW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor
  int mon_nb;
  int mon_take;
  bit mon_under;
  logic [OUTW-1:0] mon_exp;
  bit prev_stall = 0;
  logic [OUTW-1:0] prev_data;
  int prev_bits;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && bus.o_valid) begin
        check_vec("hold_data", bus.o_data, prev_data);
        check_int("hold_bits", int'(bus.o_bits), prev_bits);
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_data  = bus.o_data;
      prev_bits  = int'(bus.o_bits);
      if (bus.o_valid && bus.i_ready) begin
        if (bus.o_last) begin
          mon_nb = (blk_q.size() > 0) ? blk_q[0] - emitted : -1;
          check_int("last_bits", int'(bus.o_bits), mon_nb);
        end else begin
          check_int("full_bits", int'(bus.o_bits), OUTW);
        end
        mon_take  = (int'(bus.o_bits) > OUTW) ? OUTW : int'(bus.o_bits);
        mon_exp   = '0;
        mon_under = 0;
        for (int i = 0; i < mon_take; i++) begin
          if (exp_bits.size() > 0) mon_exp[i] = exp_bits.pop_front();
          else mon_under = 1;
        end
        check_int("stream_underflow", int'(mon_under), 0);
        check_vec("beat_data", bus.o_data, mon_exp);
        n_beats++;
        if (bus.o_last) begin
          if (blk_q.size() > 0) void'(blk_q.pop_front());
          emitted   = 0;
          n_last++;
          last_data = bus.o_data;
          last_bits = int'(bus.o_bits);
        end else begin
          emitted += OUTW;
          if (blk_q.size() > 0) check_int("block_overrun", int'(emitted > blk_q[0]), 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.i_valid) assert (int'(bus.i_len) <= MAXW);
  end

  // Downstream ready driver
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: bus.i_ready = 1'b0;
        1: bus.i_ready = 1'b1;
        default: bus.i_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send_word(input logic [MAXW-1:0] d, input int len, input bit last, output int stalls);
    bit fired = 0;
    stalls = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_len   = LENW'(len);
    bus.i_last  = last;
    while (!fired) begin
      @(negedge clk);
      if (bus.o_ready) begin
        fired = 1;
        for (int i = 0; i < len; i++) exp_bits.push_back(d[i]);
        cur_blk += len;
        if (last) begin
          blk_q.push_back(cur_blk);
          cur_blk = 0;
        end
      end else begin
        stalls++;
        if (stalls > 500) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: codeword not accepted after %0d cycles", stalls);
          fired = 1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_last(input int target, input string name);
    int g = 0;
    while (n_last < target && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    checks++;
    if (n_last < target) begin
      errors++;
      $display("FAIL %s: timed out, last beats %0d expected %0d", name, n_last, target);
    end
  endtask

  task automatic wait_beats(input int target, input string name);
    int g = 0;
    while (n_beats < target && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    checks++;
    if (n_beats < target) begin
      errors++;
      $display("FAIL %s: timed out, beats %0d expected %0d", name, n_beats, target);
    end
  endtask

  function automatic logic [MAXW-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[MAXW-1:0];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MAXW-1:0] w1, w2;
    int st, tot, base, tgt, nw, len, r;

    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_len   = '0;
    bus.i_last  = 1'b0;
    bus.i_ready = 1'b1;
    rdy_mode    = 1;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check_int("rst_o_valid", int'(bus.o_valid), 0);
    check_int("rst_o_ready", int'(bus.o_ready), 1);
    check_int("rst_o_last",  int'(bus.o_last), 0);
    check_int("rst_o_bits",  int'(bus.o_bits), 0);
    check_int("rst_o_fill",  int'(bus.o_fill), 0);
    check_vec("rst_o_data",  bus.o_data, '0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two 34-bit words closing a block
    w1   = 68'h2_AAAA_AAAA;
    w2   = 68'h1_5555_5555;
    base = n_beats;
    tgt  = n_last + 1;
    send_word(w1, 34, 0, st);
    send_word(w2, 34, 1, st);
    idle(1);
    wait_last(tgt, "t1_wait");
    check_int("t1_beats", n_beats - base, 1);
    check_vec("t1_data", last_data, {w2[33:0], w1[33:0]});
    check_int("t1_bits", last_bits, OUTW);
    check_int("t1_after_valid", int'(bus.o_valid), 0);

    // Continuous full-width words at full throughput
    base = n_beats;
    tot  = 0;
    for (int k = 0; k < 10; k++) begin
      send_word(rand_word(), 68, 0, st);
      tot += st;
    end
    tgt = n_last + 1;
    send_word(rand_word(), 0, 1, st);
    tot += st;
    idle(1);
    wait_last(tgt, "t2_wait");
    check_int("t2_stalls", tot, 0);
    check_int("t2_beats", n_beats - base, 11);

    // Backpressure: accumulator fills to 136 then o_ready drops
    rdy_mode = 0;
    idle(1);
    base = n_beats;
    send_word(rand_word(), 68, 0, st);
    send_word(rand_word(), 68, 0, st);
    idle(1);
    check_int("t3_fill_full", int'(bus.o_fill), 136);
    check_int("t3_ready_low", int'(bus.o_ready), 0);
    rdy_mode = 1;
    wait_beats(base + 1, "t3_first_beat");
    check_int("t3_ready_back", int'(bus.o_ready), 1);
    check_int("t3_fill_half", int'(bus.o_fill), 68);
    wait_beats(base + 2, "t3_second_beat");
    tgt = n_last + 1;
    send_word(rand_word(), 0, 1, st);
    idle(1);
    wait_last(tgt, "t3_close");

    // Lengths 5, 0, 3
    tgt = n_last + 1;
    send_word(68'h1F, 5, 0, st);
    send_word(68'hFFF, 0, 0, st);
    send_word(68'h5, 3, 1, st);
    idle(1);
    wait_last(tgt, "t4_wait");
    check_vec("t4_data", last_data, 68'hBF);
    check_int("t4_bits", last_bits, 8);

    // Empty block
    tgt = n_last + 1;
    send_word(68'hABC, 0, 1, st);
    idle(1);
    wait_last(tgt, "t5_wait");
    check_int("t5_bits", last_bits, 0);
    check_vec("t5_data", last_data, '0);

    // Reset while draining a 100-bit block
    rdy_mode = 0;
    idle(1);
    send_word(rand_word(), 68, 0, st);
    send_word(rand_word(), 32, 1, st);
    idle(1);
    check_int("t6_fill", int'(bus.o_fill), 100);
    check_int("t6_valid", int'(bus.o_valid), 1);
    check_int("t6_not_last", int'(bus.o_last), 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_int("t6_rst_valid", int'(bus.o_valid), 0);
    check_int("t6_rst_fill", int'(bus.o_fill), 0);
    exp_bits.delete();
    blk_q.delete();
    cur_blk = 0;
    emitted = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rdy_mode = 1;
    tgt = n_last + 1;
    send_word(rand_word(), 10, 1, st);
    idle(1);
    wait_last(tgt, "t6_wait");
    check_int("t6_fresh_bits", last_bits, 10);

    // Randomized blocks with random backpressure
    rdy_mode = 2;
    tgt = n_last;
    for (int b = 0; b < 25; b++) begin
      nw = $urandom_range(1, 6);
      for (int w = 0; w < nw; w++) begin
        r = $urandom_range(0, 5);
        case (r)
          0: len = 0;
          1: len = MAXW;
          2: len = 1;
          default: len = $urandom_range(0, MAXW);
        endcase
        send_word(rand_word(), len, (w == nw - 1), st);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      tgt++;
    end
    idle(1);
    wait_last(tgt, "rand_wait");
    idle(3);
    check_int("rand_stream_empty", exp_bits.size(), 0);
    check_int("rand_blocks_empty", blk_q.size(), 0);
    check_int("rand_final_valid", int'(bus.o_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
